// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage
// -----------------------------------------------------------------------------
// EX/MEM pipeline register with a valid/ready handshake, a one-entry skid
// buffer behind the main register (two entries total), and a flush that kills
// everything held.
//
// When MEM back-pressures, EX can keep issuing for one more cycle without
// losing an instruction. A branch or exception flush drops both stored
// entries and the input presented in that cycle.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 kill stored entries and drop this cycle's input
//   in_valid / in_ready   EX-side handshake; in_ready is register-driven
//   aluresult, rd, MemRead, MemtoReg, MemWrite, RegWrite,
//   ex_forwarded_rtdata   EX payload
//   out_valid / out_ready MEM-side handshake
//   aluresultout, rdout, MemtoRegout, mem_forwarded_rtdata
//                         registered payload (holds last value when invalid)
//   MemReadout, MemWriteout, RegWriteout
//                         control bits qualified by out_valid
//   occupancy             number of entries held (0..2)
//
// Optional build macro EXMEM_PERF_CNT_EN adds two saturating 32-bit counters:
//   stall_cycles          cycles with out_valid & !out_ready
//   flush_kills           entries discarded by flush, including a dropped input
// -----------------------------------------------------------------------------
module ex_mem_pipe_stage #(
  parameter int DATA_W        = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int ZERO_REG_KILL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     aluresult,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  MemRead,
  input  logic                  MemtoReg,
  input  logic                  MemWrite,
  input  logic                  RegWrite,
  input  logic [DATA_W-1:0]     ex_forwarded_rtdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     aluresultout,
  output logic [REG_ADDR_W-1:0] rdout,
  output logic                  MemReadout,
  output logic                  MemtoRegout,
  output logic                  MemWriteout,
  output logic                  RegWriteout,
  output logic [DATA_W-1:0]     mem_forwarded_rtdata,
  output logic [1:0]            occupancy
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_kills
`endif
);

  // Packed payload: {aluresult, rd, MemRead, MemtoReg, MemWrite, RegWrite, rtdata}
  localparam int PAY_W = 2 * DATA_W + REG_ADDR_W + 4;

  logic [PAY_W-1:0] inPay;
  logic [PAY_W-1:0] mainPay;
  logic [PAY_W-1:0] skidPay;
  logic             mainValid;
  logic             skidValid;
  logic             inFire;
  logic             outFire;
  logic             mainFree;
  logic             mainMemRead;
  logic             mainMemWrite;
  logic             mainRegWrite;
  logic             regWriteKill;

  assign inPay = {aluresult, rd, MemRead, MemtoReg, MemWrite, RegWrite,
                  ex_forwarded_rtdata};

  // Ready depends only on skid state, so there is no combinational path
  // from out_ready back to EX.
  assign in_ready  = !skidValid;
  assign out_valid = mainValid;
  assign inFire    = in_valid & in_ready & !flush;
  assign outFire   = mainValid & out_ready;
  assign mainFree  = !mainValid | outFire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainPay   <= '0;
      skidPay   <= '0;
    end else if (flush) begin
      // Payload registers keep their contents; only the valid bits drop.
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (mainFree) begin
      // inFire implies the skid is empty, so a skid refill can never coincide
      // with a skid->main promotion; the older skid entry always goes first.
      if (skidValid) begin
        mainPay   <= skidPay;
        mainValid <= 1'b1;
        skidValid <= 1'b0;
      end else if (inFire) begin
        mainPay   <= inPay;
        mainValid <= 1'b1;
      end else begin
        mainValid <= 1'b0;
      end
    end else if (inFire) begin
      skidPay   <= inPay;
      skidValid <= 1'b1;
    end
  end

  assign {aluresultout, rdout, mainMemRead, MemtoRegout, mainMemWrite,
          mainRegWrite, mem_forwarded_rtdata} = mainPay;

  // Writes to the hard-wired zero register are suppressed at the source so
  // MEM/WB never sees them as real register writes.
  generate
    if (ZERO_REG_KILL != 0) begin : gZeroKill
      assign regWriteKill = (rdout == '0);
    end else begin : gNoZeroKill
      assign regWriteKill = 1'b0;
    end
  endgenerate

  // Bubbles must never load, store or write a register.
  assign MemReadout  = mainMemRead  & mainValid;
  assign MemWriteout = mainMemWrite & mainValid;
  assign RegWriteout = mainRegWrite & mainValid & !regWriteKill;

  assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

`ifdef EXMEM_PERF_CNT_EN
  logic [1:0]  killsNow;
  logic [32:0] killSum;

  // A flush drops every held entry plus any input offered in the same cycle.
  assign killsNow = {1'b0, mainValid} + {1'b0, skidValid} + {1'b0, in_valid};
  assign killSum  = {1'b0, flush_kills} + {31'b0, killsNow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_kills  <= '0;
    end else begin
      if (mainValid && !out_ready && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush) begin
        flush_kills <= killSum[32] ? '1 : killSum[31:0];
      end
    end
  end
`endif

endmodule
